// File: rtl/mem_arbiter_pkg.sv
// Shared widths and FSM encodings for the CHIP-8 memory-port arbiter and its picker.
package mem_arbiter_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // Index width for 2..4 requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational N-way round-robin picker: the first set bit of mask strictly after
// last, wrapping modulo N. valid is low when mask is empty.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] index
);

  logic [IW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last) + k) % N);
      if (!valid && mask[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single CHIP-8 memory port between N requesters,
// with per-requester lock for bursts. IDLE -> ISSUE -> WAIT, one transaction per 3 cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        we,
  input  logic [N-1:0]        lock,
  input  logic [ADDR_W*N-1:0] addr,
  input  logic [DATA_W*N-1:0] wdata,
  output logic [N-1:0]        ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_read,
  output logic [ADDR_W-1:0]   mem_read_idx,
  input  logic [DATA_W-1:0]   mem_read_byte,
  input  logic                mem_read_ack,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_write_idx,
  output logic [DATA_W-1:0]   mem_write_byte
);

  localparam int IW = idx_w(N);

  logic [1:0]        state;
  logic [IW-1:0]     grant;
  logic [IW-1:0]     last;
  logic [IW-1:0]     owner;
  logic              owner_vld;
  logic              op_we;
  logic              op_lock;

  logic              owner_hold;
  logic [N-1:0]      eligible;
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic              done;

  logic [ADDR_W-1:0] addr_arr  [N];
  logic [DATA_W-1:0] wdata_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_split
    assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
  end

  // A lock survives only while its owner keeps both req and lock asserted; once it
  // lapses the same IDLE cycle arbitrates over everyone.
  always_comb begin
    owner_hold = owner_vld && req[owner] && lock[owner];
    eligible   = owner_hold ? (req & (N'(1) << owner)) : req;
  end

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .mask  (eligible),
    .last  (last),
    .valid (pick_vld),
    .index (pick_idx)
  );

  // Writes complete unconditionally; reads wait for the memory's acknowledge.
  assign done  = (state == ST_WAIT) && (op_we || mem_read_ack);
  assign rdata = mem_read_byte;

  always_comb begin
    ack = '0;
    if (done) ack[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      grant          <= '0;
      last           <= IW'(N - 1);
      owner          <= '0;
      owner_vld      <= 1'b0;
      op_we          <= 1'b0;
      op_lock        <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_read_idx   <= '0;
      mem_write_idx  <= '0;
      mem_write_byte <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (owner_vld && !owner_hold) owner_vld <= 1'b0;
          if (pick_vld) begin
            grant     <= pick_idx;
            op_we     <= we[pick_idx];
            op_lock   <= lock[pick_idx];
            mem_read  <= ~we[pick_idx];
            mem_write <= we[pick_idx];
            if (we[pick_idx]) begin
              mem_write_idx  <= addr_arr[pick_idx];
              mem_write_byte <= wdata_arr[pick_idx];
            end else begin
              mem_read_idx   <= addr_arr[pick_idx];
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            last      <= grant;
            owner     <= grant;
            owner_vld <= op_lock;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-requester command queues feed the DUT, a
// behavioural 4 KiB memory answers it, and a monitor checks every ack against expectations.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, we, lock;
  logic [12*N-1:0] addr;
  logic [8*N-1:0]  wdata;
  logic [N-1:0]  ack;
  logic [7:0]    rdata;
  logic          mem_read, mem_write;
  logic          mem_read_ack = 1'b0;
  logic [11:0]   mem_read_idx, mem_write_idx;
  logic [7:0]    mem_read_byte = 8'h00;
  logic [7:0]    mem_write_byte;

  typedef struct packed { logic we; logic lock; logic [11:0] a; logic [7:0] d; } cmd_t;
  typedef struct packed { logic [1:0] idx; logic rd; logic [7:0] data; } exp_t;

  cmd_t cq [N][$];
  exp_t expq[$];
  int   ack_cyc[$];
  int   cyc = 0, n_checks = 0, n_pass = 0, n_rd = 0, n_wr = 0, rd_cyc = -1;
  logic [N-1:0] last_ack = '0;
  logic [11:0]  wr_idx_seen = '0;
  logic [7:0]   wr_byte_seen = '0;
  logic [7:0]   mem [4096];

  mem_arbiter #(.N(N)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata),
    .mem_read(mem_read), .mem_read_idx(mem_read_idx), .mem_read_byte(mem_read_byte),
    .mem_read_ack(mem_read_ack), .mem_write(mem_write), .mem_write_idx(mem_write_idx),
    .mem_write_byte(mem_write_byte)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: one-cycle read latency, never reset.
  initial forever begin
    @(posedge clk);
    mem_read_ack <= mem_read;
    if (mem_read) mem_read_byte <= mem[mem_read_idx];
    if (mem_write) mem[mem_write_idx] <= mem_write_byte;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every ack.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      last_ack = ack;
      if (mem_read) begin n_rd++; rd_cyc = cyc; end
      if (mem_write) begin n_wr++; wr_idx_seen = mem_write_idx; wr_byte_seen = mem_write_byte; end
      if (ack != '0) begin
        ack_cyc.push_back(cyc);
        check("ack_onehot", 32'($onehot(ack)), 32'd1);
        if (expq.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = expq.pop_front();
          check("grant_idx", 32'(ack), 32'd1 << e.idx);
          if (e.rd) check("rdata", 32'(rdata), 32'(e.data));
        end
      end
    end
  end

  // Driver: a requester holds its command until acked, then drops req or loads the next one.
  initial begin : driver
    cmd_t c;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && last_ack[i]) req[i] = 1'b0;
        if (!req[i] && cq[i].size() > 0) begin
          c = cq[i].pop_front();
          req[i] = 1'b1;
          we[i] = c.we;
          lock[i] = c.lock;
          addr[i*12 +: 12] = c.a;
          wdata[i*8 +: 8] = c.d;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) cq[i].delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t;
    t = 0;
    while ((expq.size() != 0 || req != '0 ||
            (cq[0].size() + cq[1].size() + cq[2].size()) != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain"}, 32'(t < budget), 32'd1);
  endtask

  int rd0, wr0, a0, t;

  initial begin : main
    reset = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h030] = 8'hF0;
    for (int k = 0; k < 5; k++) mem[12'h100 + k] = 8'h10 + 8'(k);

    // Reset state
    do_reset();
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_read_idx", 32'(mem_read_idx), 0);
    check("rst_write_idx", 32'(mem_write_idx), 0);
    check("rst_write_byte", 32'(mem_write_byte), 0);
    check("rst_ack", 32'(ack), 0);

    // Single read by requester 1
    rd0 = n_rd;
    expq.push_back('{2'd1, 1'b1, 8'hF0});
    cq[1].push_back('{1'b0, 1'b0, 12'h030, 8'h00});
    wait_drain("single_read", 20);
    check("single_read_pulses", 32'(n_rd - rd0), 1);
    check("single_read_idx", 32'(mem_read_idx), 32'h030);
    check("single_read_ack_lat", 32'(ack_cyc[$] - rd_cyc), 1);

    // Write then read back
    do_reset();
    wr0 = n_wr;
    expq.push_back('{2'd0, 1'b0, 8'h00});
    expq.push_back('{2'd2, 1'b1, 8'hAB});
    cq[0].push_back('{1'b1, 1'b0, 12'h200, 8'hAB});
    cq[2].push_back('{1'b0, 1'b0, 12'h200, 8'h00});
    wait_drain("write_read", 30);
    check("write_pulses", 32'(n_wr - wr0), 1);
    check("write_idx", 32'(wr_idx_seen), 32'h200);
    check("write_byte", 32'(wr_byte_seen), 32'hAB);

    // Contention: order 0,1,2,0,1, acks 3 cycles apart
    do_reset();
    a0 = ack_cyc.size();
    expq.push_back('{2'd0, 1'b1, 8'h10});
    expq.push_back('{2'd1, 1'b1, 8'h11});
    expq.push_back('{2'd2, 1'b1, 8'h12});
    expq.push_back('{2'd0, 1'b1, 8'h13});
    expq.push_back('{2'd1, 1'b1, 8'h14});
    cq[0].push_back('{1'b0, 1'b0, 12'h100, 8'h00});
    cq[1].push_back('{1'b0, 1'b0, 12'h101, 8'h00});
    cq[2].push_back('{1'b0, 1'b0, 12'h102, 8'h00});
    cq[0].push_back('{1'b0, 1'b0, 12'h103, 8'h00});
    cq[1].push_back('{1'b0, 1'b0, 12'h104, 8'h00});
    wait_drain("contention", 40);
    check("contention_acks", 32'(ack_cyc.size() - a0), 5);
    for (int k = 1; k < 5; k++)
      if (a0 + k < ack_cyc.size())
        check("contention_spacing", 32'(ack_cyc[a0+k] - ack_cyc[a0+k-1]), 3);

    // Lock burst: requester 2 holds the port for 4 locked writes
    do_reset();
    for (int k = 0; k < 4; k++) begin
      expq.push_back('{2'd2, 1'b0, 8'h00});
      cq[2].push_back('{1'b1, 1'b1, 12'h300 + 12'(k), 8'hC0 + 8'(k)});
    end
    expq.push_back('{2'd0, 1'b1, 8'hF0});
    expq.push_back('{2'd2, 1'b1, 8'hC1});
    cq[2].push_back('{1'b0, 1'b0, 12'h301, 8'h00});
    a0 = ack_cyc.size();
    @(posedge clk);
    #2;
    cq[0].push_back('{1'b0, 1'b0, 12'h030, 8'h00});
    wait_drain("lock_burst", 60);
    check("lock_acks", 32'(ack_cyc.size() - a0), 6);
    if (ack_cyc.size() - a0 == 6)
      check("lock_release_gap", 32'(ack_cyc[a0+4] - ack_cyc[a0+3]), 3);

    // Reset during ISSUE of a read
    do_reset();
    cq[1].push_back('{1'b0, 1'b0, 12'h030, 8'h00});
    t = 0;
    while (mem_read !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    check("rst_issue_seen_read", 32'(t < 10), 1);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    check("rst_issue_mem_read", 32'(mem_read), 0);
    check("rst_issue_ack", 32'(ack), 0);
    check("rst_issue_late_rack", 32'(mem_read_ack), 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    expq.push_back('{2'd0, 1'b1, 8'h11});
    expq.push_back('{2'd1, 1'b1, 8'h12});
    cq[1].push_back('{1'b0, 1'b0, 12'h102, 8'h00});
    cq[0].push_back('{1'b0, 1'b0, 12'h101, 8'h00});
    wait_drain("after_reset", 30);

    // Requester 1 withdraws req during ISSUE
    do_reset();
    rd0 = n_rd;
    expq.push_back('{2'd1, 1'b1, 8'hF0});
    @(posedge clk);
    #1;
    req[1] = 1'b1; we[1] = 1'b0; lock[1] = 1'b0; addr[12 +: 12] = 12'h030;
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("withdrawn_ack_seen", 32'(expq.size()), 0);
    check("withdrawn_read_pulses", 32'(n_rd - rd0), 1);

    check("scoreboard_empty", 32'(expq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
